// File: rtl/uart_hex_cmd.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | uart_hex_cmd                                                                |
// | Pops bytes from a FWFT UART receive FIFO, parses ASCII hex command lines.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module uart_hex_cmd #(
  parameter int DIGITS = 4
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  rx_empty,
  input  logic [7:0]            rx_data,
  output logic                  rd_uart,
  output logic [4*DIGITS-1:0]   value,
  output logic                  value_valid,
  output logic                  cmd_err,
  output logic [2:0]            digit_cnt
);

  localparam int         c_VW      = 4 * DIGITS;
  localparam logic [2:0] c_MAX_CNT = 3'(DIGITS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  logic [c_VW-1:0]   r_acc;
  logic [2:0]        r_count;
  logic              r_err_pend;
  logic [c_VW-1:0]   r_value;
  logic              r_value_valid;
  logic              r_cmd_err;

  logic              w_pop;
  logic              w_is_dec;
  logic              w_is_alpha;
  logic              w_is_hex;
  logic              w_is_bs;
  logic              w_is_term;
  logic [3:0]        w_nibble;

  // Gated by reset so the FIFO is never drained while the parser is held.
  assign w_pop = reset && (r_state == S_IDLE) && !rx_empty;

  always_comb begin
    w_is_dec   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    w_is_alpha = ((rx_data >= 8'h41) && (rx_data <= 8'h46)) ||
                 ((rx_data >= 8'h61) && (rx_data <= 8'h66));
    w_is_hex   = w_is_dec || w_is_alpha;
    // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15.
    w_nibble   = w_is_alpha ? (rx_data[3:0] + 4'd9) : rx_data[3:0];
    w_is_bs    = (rx_data == 8'h08);
    w_is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_count       <= 3'd0;
      r_err_pend    <= 1'b0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_value_valid <= 1'b0;
      r_cmd_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_WAIT;
            if (w_is_hex) begin
              if (r_count < c_MAX_CNT) begin
                r_acc   <= {r_acc[c_VW-5:0], w_nibble};
                r_count <= r_count + 3'd1;
              end else begin
                r_err_pend <= 1'b1;
              end
            end else if (w_is_bs) begin
              if (r_count != 3'd0) begin
                r_acc   <= r_acc >> 4;
                r_count <= r_count - 3'd1;
              end
            end else if (w_is_term) begin
              // Empty lines (e.g. the LF of CRLF) end silently.
              if (r_err_pend) begin
                r_cmd_err <= 1'b1;
              end else if (r_count != 3'd0) begin
                r_value       <= r_acc;
                r_value_valid <= 1'b1;
              end
              r_acc      <= '0;
              r_count    <= 3'd0;
              r_err_pend <= 1'b0;
            end else begin
              r_err_pend <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_uart     = w_pop;
  assign value       = r_value;
  assign value_valid = r_value_valid;
  assign cmd_err     = r_cmd_err;
  assign digit_cnt   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_cmd.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_uart_hex_cmd                                                             |
// | Directed bench with a FWFT FIFO model feeding uart_hex_cmd.                 |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_uart_hex_cmd;

  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b0;
  logic        rx_empty   = 1'b1;
  logic [7:0]  rx_data    = 8'h00;
  logic        rd_uart;
  logic [15:0] value;
  logic        value_valid;
  logic        cmd_err;
  logic [2:0]  digit_cnt;

  uart_hex_cmd #(.DIGITS(4)) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .rd_uart     (rd_uart),
    .value       (value),
    .value_valid (value_valid),
    .cmd_err     (cmd_err),
    .digit_cnt   (digit_cnt)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  byte unsigned q[$];
  logic         pop_now = 1'b0;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           n_rd = 0, n_vv = 0, n_err = 0;
  int           n_b2b = 0, n_both = 0;
  int           rd_cyc[$];
  int           vv_cyc[$];
  logic [2:0]   dc_log[$];
  logic         prev_rd = 1'b0;

  // Monitor: samples mid-cycle, logs pops, strobes and digit_cnt after each pop.
  always @(negedge clk_100MHz) begin
    cyc++;
    pop_now = rd_uart;
    if (prev_rd) dc_log.push_back(digit_cnt);
    if (rd_uart) begin
      n_rd++;
      rd_cyc.push_back(cyc);
      if (prev_rd) n_b2b++;
    end
    if (value_valid) begin
      n_vv++;
      vv_cyc.push_back(cyc);
    end
    if (cmd_err) n_err++;
    if (value_valid && cmd_err) n_both++;
    prev_rd = rd_uart;
  end

  // FWFT FIFO: pop takes effect just after the edge that consumed the byte.
  always @(posedge clk_100MHz) begin
    #1;
    if (pop_now && q.size() > 0) void'(q.pop_front());
    rx_empty = (q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : q[0];
  end

  task automatic clear_log();
    n_rd = 0; n_vv = 0; n_err = 0;
    rd_cyc.delete(); vv_cyc.delete(); dc_log.delete();
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic drain();
    int budget = 200;
    while ((q.size() != 0 || !rx_empty) && budget > 0) begin
      @(negedge clk_100MHz);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL drain_timeout: queue=%0d required 0", q.size());
    end
    repeat (3) @(negedge clk_100MHz);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk_100MHz);
    checks++; if (rd_uart !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", rd_uart); end
    checks++; if (value !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h want 0000", value); end
    checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL reset_vv: got %b want 0", value_valid); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", cmd_err); end
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", digit_cnt); end
    checks++; if (n_rd != 0) begin errors++; $display("FAIL reset_pops: got %0d want 0", n_rd); end
    reset = 1'b1;
    repeat (2) @(negedge clk_100MHz);
  endtask

  task automatic test_basic();
    logic [2:0] exp_dc[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    int bad;
    clear_log();
    push_str("1aF3");
    q.push_back(8'h0D);
    drain();
    checks++; if (n_rd != 5) begin errors++; $display("FAIL basic_pops: got %0d want 5", n_rd); end
    bad = 0;
    for (int i = 1; i < rd_cyc.size(); i++) if (rd_cyc[i] - rd_cyc[i-1] != 2) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_spacing: got %0d gaps not 2 want 0", bad); end
    checks++; if (value !== 16'h1AF3) begin errors++; $display("FAIL basic_value: got %h want 1af3", value); end
    checks++; if (n_vv != 1) begin errors++; $display("FAIL basic_vv_count: got %0d want 1", n_vv); end
    checks++;
    if (vv_cyc.size() != 1 || rd_cyc.size() != 5) begin
      errors++; $display("FAIL basic_vv_timing: vv=%0d pops=%0d want 1 and 5", vv_cyc.size(), rd_cyc.size());
    end else if (vv_cyc[0] != rd_cyc[4] + 1) begin
      errors++; $display("FAIL basic_vv_timing: got cycle %0d want %0d", vv_cyc[0], rd_cyc[4] + 1);
    end
    bad = (dc_log.size() == 5) ? 0 : 1;
    if (bad == 0) for (int i = 0; i < 5; i++) if (dc_log[i] !== exp_dc[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_digit_cnt: got %0d mismatching steps want 0", bad); end
    checks++; if (n_err != 0) begin errors++; $display("FAIL basic_err: got %0d want 0", n_err); end
  endtask

  task automatic test_short_crlf();
    clear_log();
    push_str("7");
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    drain();
    checks++; if (value !== 16'h0007) begin errors++; $display("FAIL crlf_value: got %h want 0007", value); end
    checks++; if (n_vv != 1) begin errors++; $display("FAIL crlf_vv: got %0d want 1", n_vv); end
    checks++; if (n_rd != 3) begin errors++; $display("FAIL crlf_pops: got %0d want 3", n_rd); end
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL crlf_cnt: got %0d want 0", digit_cnt); end
    checks++; if (n_err != 0) begin errors++; $display("FAIL crlf_err: got %0d want 0", n_err); end
  endtask

  task automatic test_overflow();
    clear_log();
    push_str("12345");
    q.push_back(8'h0D);
    drain();
    checks++; if (n_err != 1) begin errors++; $display("FAIL ovf_err: got %0d want 1", n_err); end
    checks++; if (n_vv != 0) begin errors++; $display("FAIL ovf_vv: got %0d want 0", n_vv); end
    checks++; if (value !== 16'h0007) begin errors++; $display("FAIL ovf_value_held: got %h want 0007", value); end
    clear_log();
    push_str("FF");
    q.push_back(8'h0D);
    drain();
    checks++; if (value !== 16'h00FF) begin errors++; $display("FAIL ovf_next_value: got %h want 00ff", value); end
    checks++; if (n_vv != 1 || n_err != 0) begin errors++; $display("FAIL ovf_next_strobes: vv=%0d err=%0d want 1 0", n_vv, n_err); end
  endtask

  task automatic test_illegal_bs();
    clear_log();
    push_str("1G2");
    q.push_back(8'h0D);
    drain();
    checks++; if (n_err != 1 || n_vv != 0) begin errors++; $display("FAIL illegal_strobes: err=%0d vv=%0d want 1 0", n_err, n_vv); end
    checks++; if (value !== 16'h00FF) begin errors++; $display("FAIL illegal_value_held: got %h want 00ff", value); end
    clear_log();
    push_str("12");
    q.push_back(8'h08);
    push_str("3");
    q.push_back(8'h0D);
    drain();
    checks++; if (value !== 16'h0013) begin errors++; $display("FAIL bs_value: got %h want 0013", value); end
    checks++; if (n_vv != 1 || n_err != 0) begin errors++; $display("FAIL bs_strobes: vv=%0d err=%0d want 1 0", n_vv, n_err); end
    clear_log();
    q.push_back(8'h08);
    push_str("5");
    q.push_back(8'h0D);
    drain();
    checks++; if (value !== 16'h0005) begin errors++; $display("FAIL bs_empty_value: got %h want 0005", value); end
  endtask

  task automatic test_async_reset();
    clear_log();
    push_str("AB");
    drain();
    checks++; if (digit_cnt !== 3'd2) begin errors++; $display("FAIL ar_partial_cnt: got %0d want 2", digit_cnt); end
    clear_log();
    #2 reset = 1'b0;
    #1;
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL ar_async_cnt: got %0d want 0", digit_cnt); end
    checks++; if (value !== 16'h0000) begin errors++; $display("FAIL ar_async_value: got %h want 0000", value); end
    push_str("C");
    repeat (4) @(negedge clk_100MHz);
    checks++; if (n_rd != 0) begin errors++; $display("FAIL ar_rd_in_reset: got %0d pops want 0", n_rd); end
    reset = 1'b1;
    q.push_back(8'h0D);
    drain();
    checks++; if (value !== 16'h000C) begin errors++; $display("FAIL ar_value: got %h want 000c", value); end
    checks++; if (n_vv != 1 || n_err != 0) begin errors++; $display("FAIL ar_strobes: vv=%0d err=%0d want 1 0", n_vv, n_err); end
    checks++; if (n_rd != 2) begin errors++; $display("FAIL ar_pops: got %0d want 2", n_rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_crlf();
    test_overflow();
    test_illegal_bs();
    test_async_reset();
    checks++; if (n_b2b != 0) begin errors++; $display("FAIL rd_back_to_back: got %0d want 0", n_b2b); end
    checks++; if (n_both != 0) begin errors++; $display("FAIL strobes_together: got %0d want 0", n_both); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
